vga_sync: RTL and testbench
===========================

// Module: vga_sync
// PURPOSE
//  Timing generator for the 640x480@60Hz VGA output. Derives pixel tick from system clock,
//  runs horizontal/vertical counters, drives hsync/vsync to the DAC/connector and supplies
//  video_on, pixel_x, pixel_y to the pixel-colour generator, which returns 3-bit RGB.
//  Producer side of the pix_x/pix_y/video_on interface; one instance per display.
// PARAMETERS
//  CLK_DIV    2    system clocks per pixel (50 MHz -> 25 MHz); legal >= 1
//  H_DISPLAY  640  visible pixels per line
//  H_FRONT    16   horizontal front porch, pixels
//  H_SYNC     96   hsync pulse width, pixels
//  H_BACK     48   horizontal back porch, pixels (H_TOTAL = 800)
//  V_DISPLAY  480  visible lines per frame
//  V_FRONT    10   vertical front porch, lines
//  V_SYNC     2    vsync pulse width, lines
//  V_BACK     33   vertical back porch, lines (V_TOTAL = 525)
// PORTS
//  clk          in   1   system clock, 50 MHz
//  rst_n        in   1   synchronous reset, active low
//  hsync        out  1   horizontal sync, active low, registered
//  vsync        out  1   vertical sync, active low, registered
//  video_on     out  1   1 = current (pixel_x,pixel_y) is in visible area, registered
//  p_tick       out  1   one-clk strobe, once per pixel period
//  pixel_x      out  10  current horizontal count 0..H_TOTAL-1
//  pixel_y      out  10  current vertical count 0..V_TOTAL-1
//  frame_start  out  1   one-clk strobe when counters wrap to (0,0)
// BEHAVIOUR
//  - One clock (clk); reset synchronous, active low (rst_n). All state updates on posedge clk.
//  - Reset values: div=0, pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=0, p_tick=0,
//    frame_start=0. Reset mid-frame aborts the frame; restart from (0,0) on first clk after release.
//  - Divider: div counts 0..CLK_DIV-1, wraps to 0. p_tick=1 for exactly the clk in which
//    div==CLK_DIV-1 (registered: p_tick high in the cycle counters advance). CLK_DIV=1 -> p_tick
//    permanently 1 after reset release.
//  - On p_tick: pixel_x <= (pixel_x==H_TOTAL-1) ? 0 : pixel_x+1. When pixel_x wraps,
//    pixel_y <= (pixel_y==V_TOTAL-1) ? 0 : pixel_y+1; otherwise pixel_y holds. No p_tick -> hold.
//  - hsync/vsync/video_on/frame_start computed from the NEXT counter values and registered in the
//    same edge as the counters, so all outputs stay mutually aligned (zero skew to pixel_x/y).
//  - hsync=0 iff H_DISPLAY+H_FRONT <= pixel_x <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751).
//  - vsync=0 iff V_DISPLAY+V_FRONT <= pixel_y <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491).
//  - video_on=1 iff pixel_x < H_DISPLAY and pixel_y < V_DISPLAY. Consequence of reset value 0:
//    pixel (0,0) of first frame after reset is blanked; all later frames fully visible.
//  - frame_start=1 for one clk at edge where (V_TOTAL-1,H_TOTAL-1) -> (0,0); never at reset exit.
//  - Counter widths fixed at 10 bits; H_TOTAL and V_TOTAL must be <= 1024 (elaboration check).
//  - Frame = H_TOTAL*V_TOTAL*CLK_DIV clk = 840000 clk at defaults (~59.5 Hz).
// STRUCTURE
//  - Shared header vga_timing.vh: default H_*/V_* constants, H_TOTAL/V_TOTAL derived values,
//    also used by graphics logic for MAX_X/MAX_Y.
//  - Sub-module pixel_tick_gen (params CLK_DIV; ports clk, rst_n, p_tick): clock divider.
//  - Remaining counters and sync decode live in vga_sync top.
// TESTING
//  1 Hold rst_n=0 5 clk -> pixel_x=0,pixel_y=0,hsync=1,vsync=1,video_on=0,p_tick=0,frame_start=0.
//  2 Release reset, CLK_DIV=2 -> p_tick high every 2nd clk; pixel_x steps 0,1,2 per tick; video_on=1 from x=1.
//  3 Run one line -> hsync low exactly 96 ticks (x=656..751); video_on=0 for x>=640; x 799->0, y 0->1.
//  4 Run full frame -> vsync low for lines 490,491 (1600 ticks); y 524->0 with x 799->0; frame_start
//    one clk there; 420000 ticks between consecutive frame_start pulses.
//  5 Assert rst_n=0 at (x=300,y=200) for 1 clk -> next edge all outputs at reset values; resume from (0,0).
//  6 CLK_DIV=1 build -> p_tick constant 1; frame period 420000 clk; sync positions as in 3 and 4.

Source files
------------

// File: rtl/vga_sync_pkg.sv
// Shared VGA timing constants and helpers for the 640x480@60Hz display path.
// Graphics logic imports this package for the screen extents (MAX_X/MAX_Y).
package vga_sync_pkg;

    localparam int COORD_W     = 10;
    localparam int COORD_LIMIT = 1 << COORD_W;

    typedef logic [COORD_W-1:0] coord_t;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int H_TOTAL_DEF   = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int V_TOTAL_DEF   = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam int MAX_X = H_DISPLAY_DEF - 1;
    localparam int MAX_Y = V_DISPLAY_DEF - 1;

    // Registered sync-side outputs, all active-low except video_on.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
    } sync_t;

    // True when lo <= value <= hi (inclusive window, used for sync pulses).
    function automatic logic in_window(coord_t value, coord_t lo, coord_t hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_tick_gen.sv
// Pixel-rate strobe generator: divides the system clock by CLK_DIV and
// produces a registered one-clock strobe in the cycle the pixel counters advance.
module pixel_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic p_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("pixel_tick_gen: CLK_DIV must be at least 1");
    end

    logic [DIV_W-1:0] r_div;
    logic             r_p_tick;
    logic [DIV_W-1:0] w_div_next;

    assign w_div_next = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);

    // Divider count; the strobe is registered from the next count so it is
    // high exactly while div sits at its last value (always high when CLK_DIV=1).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div    <= '0;
            r_p_tick <= 1'b0;
        end else begin
            r_div    <= w_div_next;
            r_p_tick <= (w_div_next == DIV_LAST);
        end
    end

    assign p_tick = r_p_tick;

endmodule

// File: rtl/vga_sync.sv
// VGA timing generator: pixel/line counters plus sync and blanking decode.
// Sync, blanking and frame strobe are decoded from the next counter values so
// every output changes on the same edge as pixel_x/pixel_y.
module vga_sync
    import vga_sync_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               p_tick,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_bad_total
        $error("vga_sync: H_TOTAL and V_TOTAL must fit the 10-bit counters");
    end

    localparam coord_t H_LAST       = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST       = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VISIBLE    = coord_t'(H_DISPLAY);
    localparam coord_t V_VISIBLE    = coord_t'(V_DISPLAY);
    localparam coord_t H_SYNC_START = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t H_SYNC_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t V_SYNC_START = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t V_SYNC_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic   w_p_tick;
    coord_t r_x;
    coord_t r_y;
    sync_t  r_sync;
    logic   r_frame_start;
    logic   w_x_wrap;
    logic   w_y_wrap;
    coord_t w_x_next;
    coord_t w_y_next;
    sync_t  w_sync_next;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .p_tick (w_p_tick)
    );

    assign w_x_wrap = (r_x == H_LAST);
    assign w_y_wrap = (r_y == V_LAST);
    assign w_x_next = w_x_wrap ? '0 : r_x + coord_t'(1);
    assign w_y_next = w_x_wrap ? (w_y_wrap ? '0 : r_y + coord_t'(1)) : r_y;

    assign w_sync_next.hsync    = !in_window(w_x_next, H_SYNC_START, H_SYNC_END);
    assign w_sync_next.vsync    = !in_window(w_y_next, V_SYNC_START, V_SYNC_END);
    assign w_sync_next.video_on = (w_x_next < H_VISIBLE) && (w_y_next < V_VISIBLE);

    // Advance counters once per pixel tick and register the decode of the new position.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x           <= '0;
            r_y           <= '0;
            r_sync        <= '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0};
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (w_p_tick) begin
                r_x           <= w_x_next;
                r_y           <= w_y_next;
                r_sync        <= w_sync_next;
                r_frame_start <= w_x_wrap && w_y_wrap;
            end
        end
    end

    assign hsync       = r_sync.hsync;
    assign vsync       = r_sync.vsync;
    assign video_on    = r_sync.video_on;
    assign p_tick      = w_p_tick;
    assign pixel_x     = r_x;
    assign pixel_y     = r_y;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync. The main instance keeps the real horizontal
// timing but uses a short 8-line frame so whole frames fit in a short run;
// a second instance exercises the CLK_DIV=1 build with the same frame shape.
module tb_vga_sync;

    localparam int H_TOTAL = 800;
    localparam int VD      = 4;
    localparam int VF      = 1;
    localparam int VS      = 2;
    localparam int VB      = 1;
    localparam int V_TOTAL = VD + VF + VS + VB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hsync, vsync, video_on, p_tick, frame_start;
    logic [9:0] pixel_x, pixel_y;
    logic       rst1_n;
    logic       hs1, vs1, vo1, pt1, fs1;
    logic [9:0] px1, py1;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference position model for the main instance.
    int   mx, my, err_model;
    logic mp, mfirst, mfs;

    always #5 clk = ~clk;

    vga_sync #(
        .CLK_DIV (2), .V_DISPLAY (VD), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
    ) dut (
        .clk (clk), .rst_n (rst_n), .hsync (hsync), .vsync (vsync),
        .video_on (video_on), .p_tick (p_tick), .pixel_x (pixel_x),
        .pixel_y (pixel_y), .frame_start (frame_start)
    );

    vga_sync #(
        .CLK_DIV (1), .V_DISPLAY (VD), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
    ) dut_div1 (
        .clk (clk), .rst_n (rst1_n), .hsync (hs1), .vsync (vs1),
        .video_on (vo1), .p_tick (pt1), .pixel_x (px1),
        .pixel_y (py1), .frame_start (fs1)
    );

    // Advance one clock, update the model and tally any disagreement with the main DUT.
    task automatic step();
        logic r;
        logic ehs, evs, evo;
        r = rst_n;
        @(negedge clk);
        if (!r) begin
            mx = 0; my = 0; mp = 1'b0; mfirst = 1'b1; mfs = 1'b0;
        end else begin
            mfs = 1'b0;
            if (mp) begin
                mfirst = 1'b0;
                if (mx == H_TOTAL - 1) begin
                    mx = 0;
                    if (my == V_TOTAL - 1) begin
                        my = 0;
                        mfs = 1'b1;
                    end else begin
                        my++;
                    end
                end else begin
                    mx++;
                end
            end
            mp = !mp;
        end
        ehs = !(mx >= 656 && mx <= 751);
        evs = !(my >= VD + VF && my <= VD + VF + VS - 1);
        evo = !mfirst && (mx < 640) && (my < VD);
        if (pixel_x !== 10'(mx) || pixel_y !== 10'(my) || p_tick !== mp ||
            hsync !== ehs || vsync !== evs || video_on !== evo || frame_start !== mfs)
            err_model++;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        rst1_n = 1'b0;
        repeat (5) step();
        tests_run += 7;
        if (pixel_x !== 10'd0) begin tests_failed++; $display("[TB] FAIL reset_x got %0d want 0", pixel_x); end
        if (pixel_y !== 10'd0) begin tests_failed++; $display("[TB] FAIL reset_y got %0d want 0", pixel_y); end
        if (hsync !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_hsync got %b want 1", hsync); end
        if (vsync !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_vsync got %b want 1", vsync); end
        if (video_on !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_video_on got %b want 0", video_on); end
        if (p_tick !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_p_tick got %b want 0", p_tick); end
        if (frame_start !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_frame_start got %b want 0", frame_start); end
    endtask

    // CLK_DIV=2: p_tick on odd clocks after release, x steps every second clock, (0,0) blanked.
    task automatic test_tick_and_count();
        logic [9:0] ex;
        logic       ep, evo;
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            ep  = (k % 2) == 1;
            ex  = 10'(k / 2);
            evo = (k >= 2);
            tests_run += 3;
            if (p_tick !== ep) begin tests_failed++; $display("[TB] FAIL tick_p_tick clk %0d got %b want %b", k, p_tick, ep); end
            if (pixel_x !== ex) begin tests_failed++; $display("[TB] FAIL tick_pixel_x clk %0d got %0d want %0d", k, pixel_x, ex); end
            if (video_on !== evo) begin tests_failed++; $display("[TB] FAIL tick_video_on clk %0d got %b want %b", k, video_on, evo); end
        end
    endtask

    task automatic test_line();
        int hs_ticks, hs_first, hs_last, guard;
        int prev_x;
        bit seen_wrap;
        hs_ticks = 0; hs_first = -1; hs_last = -1; guard = 0; seen_wrap = 0;
        err_model = 0;
        prev_x = int'(pixel_x);
        while (!(my == 1 && mx == 2) && guard < 2000) begin
            step();
            guard++;
            if (mp && hsync === 1'b0) begin
                hs_ticks++;
                if (hs_first < 0) hs_first = int'(pixel_x);
                hs_last = int'(pixel_x);
            end
            if (prev_x == 799 && pixel_x === 10'd0 && pixel_y === 10'd1) seen_wrap = 1;
            prev_x = int'(pixel_x);
        end
        tests_run += 6;
        if (guard >= 2000) begin tests_failed++; $display("[TB] FAIL line_timeout got %0d clks want <2000", guard); end
        if (err_model !== 0) begin tests_failed++; $display("[TB] FAIL line_model got %0d bad samples want 0", err_model); end
        if (hs_ticks !== 96) begin tests_failed++; $display("[TB] FAIL line_hsync_width got %0d ticks want 96", hs_ticks); end
        if (hs_first !== 656) begin tests_failed++; $display("[TB] FAIL line_hsync_first got %0d want 656", hs_first); end
        if (hs_last !== 751) begin tests_failed++; $display("[TB] FAIL line_hsync_last got %0d want 751", hs_last); end
        if (!seen_wrap) begin tests_failed++; $display("[TB] FAIL line_wrap got none want x 799->0 y 0->1"); end
    endtask

    task automatic test_frame();
        int cyc, pulses, t1, t2, vs_ticks, vs_min, vs_max, off_origin;
        cyc = 0; pulses = 0; t1 = 0; t2 = 0; vs_ticks = 0; vs_min = 1000; vs_max = -1; off_origin = 0;
        err_model = 0;
        while (pulses < 2 && cyc < 30000) begin
            step();
            cyc++;
            if (pulses == 1 && mp && vsync === 1'b0) begin
                vs_ticks++;
                if (int'(pixel_y) < vs_min) vs_min = int'(pixel_y);
                if (int'(pixel_y) > vs_max) vs_max = int'(pixel_y);
            end
            if (frame_start === 1'b1) begin
                pulses++;
                if (pulses == 1) t1 = cyc; else t2 = cyc;
                if (pixel_x !== 10'd0 || pixel_y !== 10'd0) off_origin++;
            end
        end
        tests_run += 7;
        if (pulses !== 2) begin tests_failed++; $display("[TB] FAIL frame_pulses got %0d want 2", pulses); end
        if (t2 - t1 !== 12800) begin tests_failed++; $display("[TB] FAIL frame_period got %0d clks want 12800", t2 - t1); end
        if (vs_ticks !== 1600) begin tests_failed++; $display("[TB] FAIL frame_vsync_width got %0d ticks want 1600", vs_ticks); end
        if (vs_min !== VD + VF) begin tests_failed++; $display("[TB] FAIL frame_vsync_first got %0d want %0d", vs_min, VD + VF); end
        if (vs_max !== VD + VF + VS - 1) begin tests_failed++; $display("[TB] FAIL frame_vsync_last got %0d want %0d", vs_max, VD + VF + VS - 1); end
        if (off_origin !== 0) begin tests_failed++; $display("[TB] FAIL frame_start_pos got %0d off-origin pulses want 0", off_origin); end
        if (err_model !== 0) begin tests_failed++; $display("[TB] FAIL frame_model got %0d bad samples want 0", err_model); end
    endtask

    task automatic test_mid_reset();
        int guard;
        guard = 0;
        while (!(mx == 300 && my == 2) && guard < 20000) begin
            step();
            guard++;
        end
        tests_run += 1;
        if (guard >= 20000) begin tests_failed++; $display("[TB] FAIL midrst_reach got timeout want (300,2)"); end
        rst_n = 1'b0;
        step();
        tests_run += 7;
        if (pixel_x !== 10'd0) begin tests_failed++; $display("[TB] FAIL midrst_x got %0d want 0", pixel_x); end
        if (pixel_y !== 10'd0) begin tests_failed++; $display("[TB] FAIL midrst_y got %0d want 0", pixel_y); end
        if (hsync !== 1'b1) begin tests_failed++; $display("[TB] FAIL midrst_hsync got %b want 1", hsync); end
        if (vsync !== 1'b1) begin tests_failed++; $display("[TB] FAIL midrst_vsync got %b want 1", vsync); end
        if (video_on !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_video_on got %b want 0", video_on); end
        if (p_tick !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_p_tick got %b want 0", p_tick); end
        if (frame_start !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_frame_start got %b want 0", frame_start); end
        rst_n = 1'b1;
        err_model = 0;
        repeat (4) step();
        tests_run += 3;
        if (pixel_x !== 10'd2) begin tests_failed++; $display("[TB] FAIL midrst_resume_x got %0d want 2", pixel_x); end
        if (pixel_y !== 10'd0) begin tests_failed++; $display("[TB] FAIL midrst_resume_y got %0d want 0", pixel_y); end
        if (err_model !== 0) begin tests_failed++; $display("[TB] FAIL midrst_model got %0d bad samples want 0", err_model); end
    endtask

    // CLK_DIV=1 instance: constant p_tick, frame of 800*8 clocks, same sync placement.
    task automatic test_div1();
        int cyc, zero_ticks, pulses, t1, t2, hs_cnt, hs_first, hs_last, vs_cnt, bad_start;
        cyc = 0; zero_ticks = 0; pulses = 0; t1 = 0; t2 = 0;
        hs_cnt = 0; hs_first = -1; hs_last = -1; vs_cnt = 0; bad_start = 0;
        tests_run += 1;
        if (pt1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL div1_reset_p_tick got %b want 0", pt1); end
        rst1_n = 1'b1;
        while (pulses < 2 && cyc < 14000) begin
            @(negedge clk);
            cyc++;
            if (pt1 !== 1'b1) zero_ticks++;
            if (cyc == 1 && px1 !== 10'd0) bad_start++;
            if (cyc == 2 && px1 !== 10'd1) bad_start++;
            if (pulses == 0 && py1 === 10'd0 && hs1 === 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(px1);
                hs_last = int'(px1);
            end
            if (pulses == 1 && vs1 === 1'b0) vs_cnt++;
            if (fs1 === 1'b1) begin
                pulses++;
                if (pulses == 1) t1 = cyc; else t2 = cyc;
            end
        end
        tests_run += 8;
        if (pulses !== 2) begin tests_failed++; $display("[TB] FAIL div1_pulses got %0d want 2", pulses); end
        if (t2 - t1 !== 6400) begin tests_failed++; $display("[TB] FAIL div1_period got %0d clks want 6400", t2 - t1); end
        if (zero_ticks !== 0) begin tests_failed++; $display("[TB] FAIL div1_p_tick_low got %0d clks want 0", zero_ticks); end
        if (bad_start !== 0) begin tests_failed++; $display("[TB] FAIL div1_start_x got %0d bad want 0", bad_start); end
        if (hs_cnt !== 96) begin tests_failed++; $display("[TB] FAIL div1_hsync_width got %0d want 96", hs_cnt); end
        if (hs_first !== 656) begin tests_failed++; $display("[TB] FAIL div1_hsync_first got %0d want 656", hs_first); end
        if (hs_last !== 751) begin tests_failed++; $display("[TB] FAIL div1_hsync_last got %0d want 751", hs_last); end
        if (vs_cnt !== 1600) begin tests_failed++; $display("[TB] FAIL div1_vsync_width got %0d want 1600", vs_cnt); end
    endtask

    initial begin
        mx = 0; my = 0; mp = 1'b0; mfirst = 1'b1; mfs = 1'b0; err_model = 0;
        rst_n  = 1'b0;
        rst1_n = 1'b0;
        test_reset();
        test_tick_and_count();
        test_line();
        test_frame();
        test_mid_reset();
        test_div1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
